bit_sync_filt: RTL

//  Multi-channel CDC synchroniser with per-channel glitch filter and edge detect.

---
 rtl/bit_sync_pkg.sv | 19 +
 rtl/bit_filt_chan.sv | 62 ++++++
 rtl/bit_sync_filt.sv | 67 ++++++
 3 files changed

// File: rtl/bit_sync_pkg.sv
// Shared types and helpers for the bit synchroniser / glitch filter.
package bit_sync_pkg;

    localparam int MIN_STAGES = 2;
    localparam int CNT_MAX_W  = 16;

    function automatic int cnt_w(input int filt_cnt);
        int w;
        w = $clog2(filt_cnt);
        return (w < 1) ? 1 : w;
    endfunction

    // Counter is held at the widest supported size; only values up to FILT_CNT-1 occur.
    typedef struct packed {
        logic [CNT_MAX_W-1:0] cnt;
        logic                 level;
    } filt_state_t;

endpackage

// File: rtl/bit_filt_chan.sv
// One channel of the stability filter: accepts a new level after FILT_CNT
// consecutive differing samples and emits a registered 1-cycle edge pulse.
module bit_filt_chan
    import bit_sync_pkg::*;
#(
    parameter int FILT_CNT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_synced,
    input  logic i_rst_val,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_MAX_W-1:0] CNT_LAST = CNT_MAX_W'(FILT_CNT - 1);

    if (cnt_w(FILT_CNT) > CNT_MAX_W) begin : g_bad_cnt
        $error("bit_filt_chan: FILT_CNT too large for counter");
    end

    filt_state_t st_q;
    filt_state_t st_d;
    logic        rise_d;
    logic        fall_d;

    always_comb begin
        st_d   = st_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (i_en) begin
            if (i_synced == st_q.level) begin
                st_d.cnt = '0;
            end else if (st_q.cnt < CNT_LAST) begin
                st_d.cnt = st_q.cnt + 1'b1;
            end else begin
                st_d.level = i_synced;
                st_d.cnt   = '0;
                rise_d     = i_synced;
                fall_d     = ~i_synced;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            st_q.cnt   <= '0;
            st_q.level <= i_rst_val;
            o_rise     <= 1'b0;
            o_fall     <= 1'b0;
        end else begin
            st_q   <= st_d;
            o_rise <= rise_d;
            o_fall <= fall_d;
        end
    end

    assign o_level = st_q.level;

endmodule

// File: rtl/bit_sync_filt.sv
// Multi-channel CDC synchroniser with per-channel glitch filter and edge detect.
// Level/pulse latency NO_STAGES+FILT_CNT cycles; i_en=0 freezes filters only.
module bit_sync_filt
    import bit_sync_pkg::*;
#(
    parameter int             NO_STAGES = 3,
    parameter int             BUS       = 4,
    parameter int             FILT_CNT  = 4,
    parameter logic [BUS-1:0] RST_VAL   = '0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    input  logic [BUS-1:0] i_async_bit,
    output logic [BUS-1:0] o_synced_bit,
    output logic [BUS-1:0] o_level,
    output logic [BUS-1:0] o_rise,
    output logic [BUS-1:0] o_fall,
    output logic [BUS-1:0] o_stable
);

    if (NO_STAGES < MIN_STAGES) begin : g_bad_stages
        $error("bit_sync_filt: NO_STAGES must be >= 2");
    end
    if (FILT_CNT < 1) begin : g_bad_filt
        $error("bit_sync_filt: FILT_CNT must be >= 1");
    end
    if (BUS < 1) begin : g_bad_bus
        $error("bit_sync_filt: BUS must be >= 1");
    end

    logic [BUS-1:0] stage_q [NO_STAGES];

    // Chain runs every cycle; only the filters honour i_en.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NO_STAGES; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= i_async_bit;
            for (int k = 1; k < NO_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign o_synced_bit = stage_q[NO_STAGES-1];

    for (genvar n = 0; n < BUS; n++) begin : g_chan
        bit_filt_chan #(
            .FILT_CNT (FILT_CNT)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_en      (i_en),
            .i_synced  (o_synced_bit[n]),
            .i_rst_val (RST_VAL[n]),
            .o_level   (o_level[n]),
            .o_rise    (o_rise[n]),
            .o_fall    (o_fall[n])
        );
    end

    assign o_stable = ~(o_synced_bit ^ o_level);

endmodule
